// File: rtl/referee_rr.sv
// ---------------------------------------------------------------------------
// referee_rr
//   Moves words from NUM_CH source FIFOs into one destination FIFO.
//   Each cycle it picks at most one non-empty source and pops it. Sources
//   are assumed to have a one-cycle read latency. The popped word is
//   therefore presented and pushed in the following cycle.
//
//   Arbitration:
//     mode = 0 : round-robin. The search starts at the pointer and wraps.
//     mode = 1 : fixed priority, ch0 highest.
//   After every grant, in either mode, the pointer moves to (winner+1).
//   Because of this, switching modes continues from where the other
//   mode left off.
//
// Ports
//   clk          single clock, rising edge
//   reset        synchronous, active-high
//   mode         arbitration mode (see above)
//   empty        per-channel source-empty flags
//   almost_full  destination almost-full; blocks new grants
//   data_in      source read data, channel k at [k*DATA_W +: DATA_W]
//   pop          one-hot pop strobe, combinational in the grant cycle
//   push         destination push strobe, one cycle after the grant
//   data_out     word being pushed (0 when push is low)
//   ch_id        source channel of the current push
//   idle         no pending work: all sources empty, no pop, no push
//   grant_cnt    (only with REFEREE_GRANT_CNT_EN) per-channel 8-bit
//                saturating pop counters, channel k at [k*8 +: 8]
//
// Optional feature macro: REFEREE_GRANT_CNT_EN
// ---------------------------------------------------------------------------
module referee_rr #(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 12
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       mode,
  input  logic [NUM_CH-1:0]          empty,
  input  logic                       almost_full,
  input  logic [NUM_CH*DATA_W-1:0]   data_in,
  output logic [NUM_CH-1:0]          pop,
  output logic                       push,
  output logic [DATA_W-1:0]          data_out,
  output logic [$clog2(NUM_CH)-1:0]  ch_id,
  output logic                       idle
`ifdef REFEREE_GRANT_CNT_EN
  ,
  output logic [NUM_CH*8-1:0]        grant_cnt
`endif
);

  localparam int IDX_W = $clog2(NUM_CH);

  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic             push_q, push_d;
  logic [IDX_W-1:0] ch_id_q, ch_id_d;

  logic             grant;
  logic [IDX_W-1:0] win_rr;
  logic [IDX_W-1:0] win_fp;
  logic [IDX_W-1:0] win;

  // A grant is suppressed during reset. This keeps pop at zero no matter
  // what the inputs do.
  assign grant = !reset && !almost_full && !(&empty);

  // Round-robin search: the first non-empty channel at or after ptr_q.
  always_comb begin
    int  idx;
    logic found;
    win_rr = '0;
    found  = 1'b0;
    idx    = 0;
    for (int i = 0; i < NUM_CH; i++) begin
      idx = (int'(ptr_q) + i) % NUM_CH;
      if (!found && !empty[idx]) begin
        win_rr = IDX_W'(idx);
        found  = 1'b1;
      end
    end
  end

  // Fixed priority: scan downward so the lowest index writes last.
  always_comb begin
    win_fp = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (!empty[i]) begin
        win_fp = IDX_W'(i);
      end
    end
  end

  assign win = mode ? win_fp : win_rr;

  always_comb begin
    pop = '0;
    if (grant) begin
      pop[win] = 1'b1;
    end
  end

  always_comb begin
    ptr_d   = ptr_q;
    push_d  = grant;
    ch_id_d = ch_id_q;
    if (grant) begin
      ch_id_d = win;
      // Explicit wrap so that a NUM_CH that is not a power of two works.
      if (int'(win) == NUM_CH - 1) begin
        ptr_d = '0;
      end else begin
        ptr_d = win + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q   <= '0;
      push_q  <= 1'b0;
      ch_id_q <= '0;
    end else begin
      ptr_q   <= ptr_d;
      push_q  <= push_d;
      ch_id_q <= ch_id_d;
    end
  end

  assign push  = push_q;
  assign ch_id = ch_id_q;

  // Source data arrives one cycle after the pop. It is selected with the
  // registered winner, which lines up with that data.
  always_comb begin
    data_out = '0;
    if (push_q) begin
      data_out = data_in[int'(ch_id_q)*DATA_W +: DATA_W];
    end
  end

  assign idle = (&empty) && (pop == '0) && !push_q;

`ifdef REFEREE_GRANT_CNT_EN
  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_cnt
      logic [7:0] cnt_q, cnt_d;

      always_comb begin
        cnt_d = cnt_q;
        if (pop[gi] && cnt_q != 8'hFF) begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      always_ff @(posedge clk) begin
        if (reset) begin
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_d;
        end
      end

      assign grant_cnt[gi*8 +: 8] = cnt_q;
    end
  endgenerate
`endif

endmodule

// File: tb/tb_referee_rr.sv
module tb_referee_rr;

  localparam int NUM_CH = 4;
  localparam int DATA_W = 12;

  logic                      clk;
  logic                      reset;
  logic                      mode;
  logic [NUM_CH-1:0]         empty;
  logic                      almost_full;
  logic [NUM_CH*DATA_W-1:0]  data_in;
  logic [NUM_CH-1:0]         pop;
  logic                      push;
  logic [DATA_W-1:0]         data_out;
  logic [1:0]                ch_id;
  logic                      idle;
`ifdef REFEREE_GRANT_CNT_EN
  logic [NUM_CH*8-1:0]       grant_cnt;
`endif

  int checks   = 0;
  int failures = 0;

  referee_rr #(.NUM_CH(NUM_CH), .DATA_W(DATA_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .mode        (mode),
    .empty       (empty),
    .almost_full (almost_full),
    .data_in     (data_in),
    .pop         (pop),
    .push        (push),
    .data_out    (data_out),
    .ch_id       (ch_id),
    .idle        (idle)
`ifdef REFEREE_GRANT_CNT_EN
    ,
    .grant_cnt   (grant_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Channel k presents the word 12'hA00 + k.
  function automatic logic [DATA_W-1:0] word_of(input logic [1:0] ch);
    return 12'hA00 + {10'd0, ch};
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset       = 1'b1;
    mode        = 1'b0;
    empty       = '1;
    almost_full = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1; empty = 4'b0000; almost_full = 1'b0; mode = 1'b0;
    #1;
    checks++;
    if (pop !== 4'b0000) begin failures++; $display("FAIL reset_pop got=%b exp=0000", pop); end
    @(negedge clk); #1;
    checks++;
    if (push !== 1'b0) begin failures++; $display("FAIL reset_push got=%b exp=0", push); end
    checks++;
    if (ch_id !== 2'd0) begin failures++; $display("FAIL reset_ch_id got=%0d exp=0", ch_id); end
    checks++;
    if (data_out !== 12'h000) begin failures++; $display("FAIL reset_data_out got=%h exp=000", data_out); end
    checks++;
    if (idle !== 1'b0) begin failures++; $display("FAIL reset_idle_busy got=%b exp=0", idle); end
    empty = 4'b1111; #1;
    checks++;
    if (idle !== 1'b1) begin failures++; $display("FAIL reset_idle got=%b exp=1", idle); end
    $display("test_reset done");
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_pop;
    logic [1:0] exp_ch;
    do_reset();
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      reset = 1'b0; mode = 1'b0; empty = 4'b0000; almost_full = 1'b0;
      #1;
      exp_pop = 4'b0001 << (k % 4);
      exp_ch  = 2'((k + 3) % 4);
      checks++;
      if (pop !== exp_pop) begin failures++; $display("FAIL rr_pop c%0d got=%b exp=%b", k, pop, exp_pop); end
      checks++;
      if (push !== (k != 0)) begin failures++; $display("FAIL rr_push c%0d got=%b exp=%b", k, push, (k != 0)); end
      if (k != 0) begin
        checks++;
        if (ch_id !== exp_ch) begin failures++; $display("FAIL rr_ch_id c%0d got=%0d exp=%0d", k, ch_id, exp_ch); end
        checks++;
        if (data_out !== word_of(exp_ch)) begin failures++; $display("FAIL rr_data c%0d got=%h exp=%h", k, data_out, word_of(exp_ch)); end
      end
      $display("rr c%0d pop=%b push=%b ch_id=%0d data=%h", k, pop, push, ch_id, data_out);
    end
  endtask

  task automatic test_fixed_priority();
    // c0-c3: fixed priority with ch2 empty -> ch0 always wins.
    // c4: round-robin resumes from pointer 1 (not reset by mode change).
    // c5: fixed priority again in the same cycle -> ch0.
    logic [3:0] t_mode  [6] = '{1, 1, 1, 1, 0, 1};
    logic [3:0] t_empty [6] = '{4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0000, 4'b0000};
    logic [3:0] t_pop   [6] = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0010, 4'b0001};
    logic [1:0] t_ch    [6] = '{0, 0, 0, 0, 0, 1};
    do_reset();
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      reset = 1'b0; mode = t_mode[k][0]; empty = t_empty[k]; almost_full = 1'b0;
      #1;
      checks++;
      if (pop !== t_pop[k]) begin failures++; $display("FAIL fp_pop c%0d got=%b exp=%b", k, pop, t_pop[k]); end
      if (k != 0) begin
        checks++;
        if (push !== 1'b1 || ch_id !== t_ch[k]) begin
          failures++; $display("FAIL fp_push c%0d got=%b/%0d exp=1/%0d", k, push, ch_id, t_ch[k]);
        end
      end
      $display("fp c%0d mode=%b pop=%b push=%b ch_id=%0d", k, mode, pop, push, ch_id);
    end
  endtask

  task automatic test_wrap_and_empty();
    logic [3:0] t_empty [6] = '{4'b1110, 4'b1101, 4'b1110, 4'b1010, 4'b1111, 4'b1111};
    logic [3:0] t_pop   [6] = '{4'b0001, 4'b0010, 4'b0001, 4'b0100, 4'b0000, 4'b0000};
    logic       t_push  [6] = '{0, 1, 1, 1, 1, 0};
    logic [1:0] t_ch    [6] = '{0, 0, 1, 0, 2, 0};
    logic       t_idle  [6] = '{0, 0, 0, 0, 0, 1};
    do_reset();
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      reset = 1'b0; mode = 1'b0; empty = t_empty[k]; almost_full = 1'b0;
      #1;
      checks++;
      if (pop !== t_pop[k]) begin failures++; $display("FAIL wrap_pop c%0d got=%b exp=%b", k, pop, t_pop[k]); end
      checks++;
      if (push !== t_push[k]) begin failures++; $display("FAIL wrap_push c%0d got=%b exp=%b", k, push, t_push[k]); end
      if (t_push[k]) begin
        checks++;
        if (ch_id !== t_ch[k]) begin failures++; $display("FAIL wrap_ch_id c%0d got=%0d exp=%0d", k, ch_id, t_ch[k]); end
      end else begin
        checks++;
        if (data_out !== 12'h000) begin failures++; $display("FAIL wrap_data_zero c%0d got=%h exp=000", k, data_out); end
      end
      checks++;
      if (idle !== t_idle[k]) begin failures++; $display("FAIL wrap_idle c%0d got=%b exp=%b", k, idle, t_idle[k]); end
      $display("wrap c%0d empty=%b pop=%b push=%b ch_id=%0d idle=%b", k, empty, pop, push, ch_id, idle);
    end
  endtask

  task automatic test_almost_full();
    logic [3:0] t_pop  [8] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0000, 4'b0010, 4'b0100};
    logic       t_push [8] = '{0, 1, 1, 1, 1, 1, 0, 1};
    logic [1:0] t_ch   [8] = '{0, 0, 1, 2, 3, 0, 0, 1};
    do_reset();
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      reset = 1'b0; mode = 1'b0; empty = 4'b0000; almost_full = (k == 5);
      #1;
      checks++;
      if (pop !== t_pop[k]) begin failures++; $display("FAIL af_pop c%0d got=%b exp=%b", k, pop, t_pop[k]); end
      checks++;
      if (push !== t_push[k]) begin failures++; $display("FAIL af_push c%0d got=%b exp=%b", k, push, t_push[k]); end
      if (t_push[k]) begin
        checks++;
        if (data_out !== word_of(t_ch[k])) begin failures++; $display("FAIL af_data c%0d got=%h exp=%h", k, data_out, word_of(t_ch[k])); end
      end
      $display("af c%0d almost_full=%b pop=%b push=%b ch_id=%0d", k, almost_full, pop, push, ch_id);
    end
  endtask

  task automatic test_reset_mid_stream();
    do_reset();
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      reset = 1'b0; mode = 1'b0; empty = 4'b0000; almost_full = 1'b0;
    end
    // Pointer is now 2. Reset is asserted right after the ch1 grant.
    @(negedge clk);
    reset = 1'b1; #1;
    checks++;
    if (pop !== 4'b0000) begin failures++; $display("FAIL rst_mid_pop got=%b exp=0000", pop); end
    @(negedge clk); #1;
    checks++;
    if (push !== 1'b0) begin failures++; $display("FAIL rst_mid_push got=%b exp=0", push); end
    checks++;
    if (pop !== 4'b0000) begin failures++; $display("FAIL rst_mid_pop2 got=%b exp=0000", pop); end
    @(negedge clk);
    reset = 1'b0; #1;
    checks++;
    if (pop !== 4'b0001) begin failures++; $display("FAIL rst_first_grant got=%b exp=0001", pop); end
    @(negedge clk); #1;
    checks++;
    if (push !== 1'b1 || ch_id !== 2'd0) begin
      failures++; $display("FAIL rst_first_push got=%b/%0d exp=1/0", push, ch_id);
    end
    $display("reset_mid_stream pop=%b push=%b ch_id=%0d", pop, push, ch_id);
  endtask

`ifdef REFEREE_GRANT_CNT_EN
  task automatic test_grant_cnt();
    do_reset();
    #1;
    checks++;
    if (grant_cnt !== 32'h0) begin failures++; $display("FAIL cnt_reset got=%h exp=00000000", grant_cnt); end
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      reset = 1'b0; mode = 1'b0; empty = 4'b0111; almost_full = 1'b0;
      if (k == 10) begin
        #1;
        checks++;
        if (grant_cnt !== 32'h0A00_0000) begin failures++; $display("FAIL cnt_mid got=%h exp=0a000000", grant_cnt); end
      end
    end
    @(negedge clk);
    empty = 4'b1111; #1;
    checks++;
    if (grant_cnt !== 32'hFF00_0000) begin failures++; $display("FAIL cnt_sat got=%h exp=ff000000", grant_cnt); end
    $display("grant_cnt=%h", grant_cnt);
  endtask
`endif

  initial begin
    reset       = 1'b1;
    mode        = 1'b0;
    empty       = '1;
    almost_full = 1'b0;
    for (int k = 0; k < NUM_CH; k++) begin
      data_in[k*DATA_W +: DATA_W] = word_of(2'(k));
    end
    test_reset();
    test_round_robin();
    test_fixed_priority();
    test_wrap_and_empty();
    test_almost_full();
    test_reset_mid_stream();
`ifdef REFEREE_GRANT_CNT_EN
    test_grant_cnt();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
